// File: rtl/i2s_audio_rx.sv
// I2S receiver: oversampled bclk/lrclk/sdata, emits stereo PCM frames.
// Define I2S_RX_LOCK_EN to add frame-length lock detection and gating.
module i2s_audio_rx #(
   parameter int audio_bits     = 16,
   parameter int timeout_cycles = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  bclk,
   input  logic                  lrclk,
   input  logic                  sdata,
   output logic [audio_bits-1:0] pcm_l,
   output logic [audio_bits-1:0] pcm_r,
   output logic                  pcm_valid,
   output logic                  locked
);

   localparam logic [5:0] AB6 = 6'(audio_bits);
   localparam logic [7:0] TO8 = 8'(timeout_cycles);

   logic [2:0]            r_bclk_s;
   logic [1:0]            r_lr_s;
   logic [1:0]            r_sd_s;
   logic                  r_lr_prev;
   logic [5:0]            r_bitcnt;
   logic [audio_bits-1:0] r_sh;
   logic [audio_bits-1:0] r_left_hold;
   logic                  r_have_left;
   logic [7:0]            r_to;

   logic                  w_bedge;
   logic                  w_lr;
   logic                  w_sd;
   logic                  w_chg;
   logic [5:0]            w_cnt_inc;
   logic [5:0]            w_shamt;
   logic [audio_bits-1:0] w_one;
   logic [audio_bits-1:0] w_word;
   logic                  w_emit;

   assign w_bedge   = r_bclk_s[1] & ~r_bclk_s[2];
   assign w_lr      = r_lr_s[1];
   assign w_sd      = r_sd_s[1];
   assign w_chg     = w_lr ^ r_lr_prev;
   assign w_cnt_inc = (r_bitcnt == 6'd63) ? 6'd63 : r_bitcnt + 6'd1;
   assign w_shamt   = AB6 - 6'd1 - r_bitcnt;
   assign w_one     = {{(audio_bits-1){1'b0}}, w_sd};
   // current bit merged into the word; bits past audio_bits are dropped
   assign w_word    = (r_bitcnt < AB6) ? (r_sh | (w_one << w_shamt)) : r_sh;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_bclk_s <= '0;
         r_lr_s   <= '0;
         r_sd_s   <= '0;
      end else begin
         r_bclk_s <= {r_bclk_s[1:0], bclk};
         r_lr_s   <= {r_lr_s[0], lrclk};
         r_sd_s   <= {r_sd_s[0], sdata};
      end
   end

`ifdef I2S_RX_LOCK_EN
   logic [5:0] r_len_l;
   logic       r_good;
   logic       r_locked;
   logic       w_wf;

   assign w_wf   = (r_len_l == w_cnt_inc) && (r_len_l >= AB6);
   assign w_emit = w_wf && (r_locked || r_good);
   assign locked = r_locked;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_len_l  <= '0;
         r_good   <= 1'b0;
         r_locked <= 1'b0;
      end else if (w_bedge) begin
         if (w_chg && !r_lr_prev) begin
            r_len_l <= w_cnt_inc;
         end else if (w_chg && r_have_left) begin
            r_good   <= w_wf;
            r_locked <= w_wf && (r_locked || r_good);
         end
      end else if (r_to == 8'd0) begin
         r_good   <= 1'b0;
         r_locked <= 1'b0;
      end
   end
`else
   assign w_emit = 1'b1;
   assign locked = 1'b1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lr_prev   <= 1'b0;
         r_bitcnt    <= '0;
         r_sh        <= '0;
         r_left_hold <= '0;
         r_have_left <= 1'b0;
         r_to        <= TO8;
         pcm_l       <= '0;
         pcm_r       <= '0;
         pcm_valid   <= 1'b0;
      end else begin
         pcm_valid <= 1'b0;
         if (w_bedge) begin
            r_to      <= TO8;
            r_lr_prev <= w_lr;
            if (!w_chg) begin
               r_sh     <= w_word;
               r_bitcnt <= w_cnt_inc;
            end else begin
               // I2S one-bit delay: this edge carries the LSB of channel lr_prev
               r_sh     <= '0;
               r_bitcnt <= '0;
               if (!r_lr_prev) begin
                  r_left_hold <= w_word;
                  r_have_left <= 1'b1;
               end else begin
                  r_have_left <= 1'b0;
                  if (r_have_left && w_emit) begin
                     pcm_l     <= r_left_hold;
                     pcm_r     <= w_word;
                     pcm_valid <= 1'b1;
                  end
               end
            end
         end else if (r_to != 8'd0) begin
            r_to <= r_to - 8'd1;
         end else begin
            r_have_left <= 1'b0;
            r_bitcnt    <= '0;
            r_sh        <= '0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Bench for i2s_audio_rx: random I2S streams against a bit-queue model.
// Works with or without I2S_RX_LOCK_EN defined.
module tb_i2s_audio_rx;

   localparam int AB = 16;
`ifdef I2S_RX_LOCK_EN
   localparam logic LOCK_RST = 1'b0;
`else
   localparam logic LOCK_RST = 1'b1;
`endif

   typedef struct packed {
      logic [AB-1:0] l;
      logic [AB-1:0] r;
   } fr_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          bclk;
   logic          lrclk;
   logic          sdata;
   logic [AB-1:0] pcm_l;
   logic [AB-1:0] pcm_r;
   logic          pcm_valid;
   logic          locked;

   int  checks = 0;
   int  errors = 0;
   int  wide   = 0;
   logic prev_v = 1'b0;
   fr_t obs[$];
   fr_t expq[$];

   bit            m_bits[$];
   logic          m_lr;
   logic [AB-1:0] m_hold;
   logic [AB-1:0] m_out_l;
   logic [AB-1:0] m_out_r;
   int            m_lenl;
   bit            m_have;
   int            m_good;
   logic          m_locked;
   logic          pend;

   always #5 clk = ~clk;

   i2s_audio_rx #(
      .audio_bits(AB),
      .timeout_cycles(255)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bclk(bclk),
      .lrclk(lrclk),
      .sdata(sdata),
      .pcm_l(pcm_l),
      .pcm_r(pcm_r),
      .pcm_valid(pcm_valid),
      .locked(locked)
   );

   always @(negedge clk) begin
      if (pcm_valid) obs.push_back({pcm_l, pcm_r});
      if (pcm_valid && prev_v) wide++;
      prev_v = pcm_valid;
   end

   function automatic void model_reset();
      m_bits.delete();
      m_lr     = 1'b0;
      m_hold   = '0;
      m_have   = 0;
      m_good   = 0;
      m_lenl   = 0;
      m_locked = LOCK_RST;
      m_out_l  = '0;
      m_out_r  = '0;
   endfunction

   function automatic void model_timeout();
      m_bits.delete();
      m_have = 0;
      m_good = 0;
`ifdef I2S_RX_LOCK_EN
      m_locked = 1'b0;
`endif
   endfunction

   // A completed word keeps its first AB bits MSB-first, zero padded.
   function automatic void model_word(logic ch);
      int n;
      bit wf;
      logic [AB-1:0] w;
      n = (m_bits.size() > 63) ? 63 : m_bits.size();
      w = '0;
      for (int i = 0; i < AB && i < m_bits.size(); i++) w[AB-1-i] = m_bits[i];
      m_bits.delete();
      if (ch == 1'b0) begin
         m_hold = w;
         m_lenl = n;
         m_have = 1;
      end else if (m_have) begin
         m_have = 0;
         wf = (m_lenl == n) && (n >= AB);
`ifdef I2S_RX_LOCK_EN
         if (wf) begin
            m_good++;
            if (m_good >= 2) m_locked = 1'b1;
         end else begin
            m_good   = 0;
            m_locked = 1'b0;
         end
`else
         wf = 1;
`endif
         if (wf && m_locked) begin
            expq.push_back({m_hold, w});
            m_out_l = m_hold;
            m_out_r = w;
         end
      end
   endfunction

   function automatic void model_slot(logic lr, logic sd);
      m_bits.push_back(sd);
      if (lr != m_lr) model_word(m_lr);
      m_lr = lr;
   endfunction

   task automatic slot(input logic lr, input logic sd);
      lrclk = lr;
      sdata = sd;
      model_slot(lr, sd);
      repeat (2) @(negedge clk);
      bclk = 1'b1;
      repeat (4) @(negedge clk);
      bclk = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_half(input logic c, input logic [63:0] v, input int n);
      slot(c, pend);
      for (int i = 1; i < n; i++) slot(c, v[n-i]);
      pend = v[0];
   endtask

   task automatic send_frame(input logic [63:0] l, input int nl,
                             input logic [63:0] r, input int nr);
      send_half(1'b0, l, nl);
      send_half(1'b1, r, nr);
   endtask

   task automatic flush();
      slot(~lrclk, pend);
   endtask

   task automatic settle();
      repeat (10) @(negedge clk);
   endtask

   task automatic idle_timeout();
      repeat (300) @(negedge clk);
      model_timeout();
   endtask

   function automatic logic [63:0] rnd();
      return {$urandom(), $urandom()};
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      bclk    = 1'b0;
      lrclk   = 1'b0;
      sdata   = 1'b0;
      pend    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (pcm_l !== 16'h0) begin
         errors++;
         $display("FAIL reset_pcm_l got %h want 0000", pcm_l);
      end
      checks++;
      if (pcm_r !== 16'h0) begin
         errors++;
         $display("FAIL reset_pcm_r got %h want 0000", pcm_r);
      end
      checks++;
      if (pcm_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid got %b want 0", pcm_valid);
      end
      checks++;
      if (locked !== LOCK_RST) begin
         errors++;
         $display("FAIL reset_locked got %b want %b", locked, LOCK_RST);
      end
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (pcm_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid_after got %b want 0", pcm_valid);
      end
   endtask

   task automatic test_basic();
      fr_t o, e;
      send_half(1'b1, rnd(), 16);
      for (int k = 0; k < 3; k++) send_frame(rnd(), 16, rnd(), 16);
      send_frame(64'h8001, 16, 64'h7FFE, 16);
      flush();
      settle();
      checks++;
      if (pcm_l !== 16'h8001 || pcm_r !== 16'h7FFE) begin
         errors++;
         $display("FAIL basic_literal got %h/%h want 8001/7ffe", pcm_l, pcm_r);
      end
      checks++;
      if (obs.size() != expq.size()) begin
         errors++;
         $display("FAIL basic_count got %0d want %0d", obs.size(), expq.size());
      end
      while (obs.size() > 0 && expq.size() > 0) begin
         o = obs.pop_front();
         e = expq.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL basic_frame got %h want %h", o, e);
         end
      end
      obs.delete();
      expq.delete();
   endtask

   task automatic test_truncate();
      fr_t o, e;
      idle_timeout();
      send_half(1'b1, rnd(), 24);
      for (int k = 0; k < 2; k++) send_frame(rnd(), 24, rnd(), 24);
      send_frame(64'h123456, 24, rnd(), 24);
      flush();
      settle();
      checks++;
      if (pcm_l !== 16'h1234) begin
         errors++;
         $display("FAIL trunc_literal got %h want 1234", pcm_l);
      end
      checks++;
      if (obs.size() != expq.size()) begin
         errors++;
         $display("FAIL trunc_count got %0d want %0d", obs.size(), expq.size());
      end
      while (obs.size() > 0 && expq.size() > 0) begin
         o = obs.pop_front();
         e = expq.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL trunc_frame got %h want %h", o, e);
         end
      end
      obs.delete();
      expq.delete();
   endtask

   task automatic test_pad();
      fr_t o, e;
      idle_timeout();
      send_half(1'b1, rnd(), 8);
      for (int k = 0; k < 2; k++) send_frame(rnd(), 8, rnd(), 8);
      send_frame(rnd(), 8, 64'hA5, 8);
      flush();
      settle();
`ifndef I2S_RX_LOCK_EN
      checks++;
      if (pcm_r !== 16'hA500) begin
         errors++;
         $display("FAIL pad_literal got %h want a500", pcm_r);
      end
`endif
      checks++;
      if (obs.size() != expq.size()) begin
         errors++;
         $display("FAIL pad_count got %0d want %0d", obs.size(), expq.size());
      end
      while (obs.size() > 0 && expq.size() > 0) begin
         o = obs.pop_front();
         e = expq.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL pad_frame got %h want %h", o, e);
         end
      end
      obs.delete();
      expq.delete();
   endtask

   task automatic test_random_lengths();
      fr_t o, e;
      int nl, nr;
      idle_timeout();
      send_half(1'b1, rnd(), 16);
      for (int k = 0; k < 8; k++) begin
         nl = $urandom_range(1, 40);
         nr = ($urandom_range(0, 1) == 1) ? nl : $urandom_range(1, 40);
         send_frame(rnd(), nl, rnd(), nr);
      end
      flush();
      settle();
      checks++;
      if (obs.size() != expq.size()) begin
         errors++;
         $display("FAIL rand_count got %0d want %0d", obs.size(), expq.size());
      end
      while (obs.size() > 0 && expq.size() > 0) begin
         o = obs.pop_front();
         e = expq.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rand_frame got %h want %h", o, e);
         end
      end
      obs.delete();
      expq.delete();
      checks++;
      if (wide !== 0) begin
         errors++;
         $display("FAIL valid_width got %0d long strobes want 0", wide);
      end
   endtask

   task automatic test_timeout();
      fr_t o, e;
      idle_timeout();
      send_half(1'b1, rnd(), 16);
      for (int k = 0; k < 3; k++) send_frame(rnd() | 64'h8000, 16, rnd(), 16);
      send_half(1'b0, rnd(), 16);
      for (int k = 0; k < 6; k++) slot(1'b1, 1'($urandom_range(0, 1)));
      idle_timeout();
      checks++;
      if (pcm_l !== m_out_l || pcm_r !== m_out_r) begin
         errors++;
         $display("FAIL to_hold got %h/%h want %h/%h", pcm_l, pcm_r, m_out_l, m_out_r);
      end
      checks++;
      if (locked !== m_locked) begin
         errors++;
         $display("FAIL to_locked got %b want %b", locked, m_locked);
      end
      for (int k = 0; k < 10; k++) slot(1'b1, 1'($urandom_range(0, 1)));
      pend = 1'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) send_frame(rnd(), 16, rnd(), 16);
      flush();
      settle();
      checks++;
      if (obs.size() != expq.size()) begin
         errors++;
         $display("FAIL to_count got %0d want %0d", obs.size(), expq.size());
      end
      while (obs.size() > 0 && expq.size() > 0) begin
         o = obs.pop_front();
         e = expq.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL to_frame got %h want %h", o, e);
         end
      end
      obs.delete();
      expq.delete();
   endtask

   task automatic test_reset_mid();
      fr_t o, e;
      logic [63:0] v;
      idle_timeout();
      send_half(1'b1, rnd(), 16);
      for (int k = 0; k < 2; k++) send_frame(rnd() | 64'h8000, 16, rnd() | 64'h1, 16);
      v = rnd();
      slot(1'b0, pend);
      for (int i = 1; i < 8; i++) slot(1'b0, v[16-i]);
      checks++;
      if (obs.size() != expq.size()) begin
         errors++;
         $display("FAIL rst_pre_count got %0d want %0d", obs.size(), expq.size());
      end
      obs.delete();
      expq.delete();
      reset_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (pcm_l !== 16'h0 || pcm_r !== 16'h0) begin
         errors++;
         $display("FAIL rst_mid_pcm got %h/%h want 0000/0000", pcm_l, pcm_r);
      end
      checks++;
      if (pcm_valid !== 1'b0 || locked !== LOCK_RST) begin
         errors++;
         $display("FAIL rst_mid_ctl got %b/%b want 0/%b", pcm_valid, locked, LOCK_RST);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 8; i < 16; i++) slot(1'b0, v[16-i]);
      pend = v[0];
      send_half(1'b1, rnd(), 16);
      for (int k = 0; k < 2; k++) send_frame(rnd(), 16, rnd(), 16);
      flush();
      settle();
      checks++;
      if (obs.size() != expq.size()) begin
         errors++;
         $display("FAIL rst_count got %0d want %0d", obs.size(), expq.size());
      end
      while (obs.size() > 0 && expq.size() > 0) begin
         o = obs.pop_front();
         e = expq.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rst_frame got %h want %h", o, e);
         end
      end
      obs.delete();
      expq.delete();
   endtask

`ifdef I2S_RX_LOCK_EN
   task automatic test_lock();
      fr_t o, e;
      idle_timeout();
      send_half(1'b1, rnd(), 16);
      send_frame(rnd(), 16, rnd(), 16);
      send_frame(rnd(), 16, rnd(), 16);
      send_half(1'b0, rnd(), 16);
      settle();
      checks++;
      if (locked !== 1'b1 || obs.size() != 1) begin
         errors++;
         $display("FAIL lock_rise got locked=%b strobes=%0d want 1/1", locked, obs.size());
      end
      send_half(1'b1, rnd(), 16);
      send_frame(rnd(), 18, rnd(), 16);
      flush();
      settle();
      checks++;
      if (locked !== 1'b0 || obs.size() != 2) begin
         errors++;
         $display("FAIL lock_fall got locked=%b strobes=%0d want 0/2", locked, obs.size());
      end
      while (obs.size() > 0 && expq.size() > 0) begin
         o = obs.pop_front();
         e = expq.pop_front();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL lock_frame got %h want %h", o, e);
         end
      end
      obs.delete();
      expq.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_truncate();
      test_pad();
      test_random_lengths();
      test_timeout();
      test_reset_mid();
`ifdef I2S_RX_LOCK_EN
      test_lock();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
